// File: rtl/imul_result_wb_buffer_if.sv
// Result-port bundle between the integer multiplier, the writeback buffer
// and the shared result-bus arbiter.
// The slave modport is the buffer's view. The master modport is the view of
// the multiplier and arbiter side.
interface imul_result_wb_buffer_if #(
    parameter int DATA_W = 64,
    parameter int PRD_W  = 7,
    parameter int ROB_W  = 6,
    parameter int KILL_W = 4
);
    logic              In_Valid;
    logic              In_Ready;
    logic              In_RegWe;
    logic              In_PrdType;
    logic [PRD_W-1:0]  In_Prd;
    logic [ROB_W-1:0]  In_RobIndex;
    logic [KILL_W-1:0] In_KillMask;
    logic [DATA_W-1:0] In_Value;

    logic              Out_Valid;
    logic              Out_Grant;
    logic              Out_RegWe;
    logic              Out_PrdType;
    logic [PRD_W-1:0]  Out_Prd;
    logic [ROB_W-1:0]  Out_RobIndex;
    logic [DATA_W-1:0] Out_Value;

    modport slave (
        input  In_Valid, In_RegWe, In_PrdType, In_Prd, In_RobIndex, In_KillMask, In_Value,
        output In_Ready,
        output Out_Valid, Out_RegWe, Out_PrdType, Out_Prd, Out_RobIndex, Out_Value,
        input  Out_Grant
    );

    modport master (
        output In_Valid, In_RegWe, In_PrdType, In_Prd, In_RobIndex, In_KillMask, In_Value,
        input  In_Ready,
        input  Out_Valid, Out_RegWe, Out_PrdType, Out_Prd, Out_RobIndex, Out_Value,
        output Out_Grant
    );
endinterface

// File: rtl/imul_result_wb_buffer.sv
// Multiplier result writeback buffer.
// Small circular FIFO that parks completed multiply results until the
// result-bus arbiter grants this port. Each entry carries an alive bit.
// A branch kill clears the alive bit of every matching entry. A dead head is
// then retired silently, one entry per cycle, and is never shown on the bus.
// Flush empties the buffer at the next edge.
// Optional feature macro IMUL_WB_BYPASS_EN: when the buffer is empty, a live
// input is presented on the output in the same cycle. If it is also granted
// in that cycle, it is never stored.
module imul_result_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int PRD_W  = 7,
    parameter int ROB_W  = 6,
    parameter int KILL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Flush,
    input  logic              Kill_Enable,
    input  logic [KILL_W-1:0] Kill_VKillMask,
    imul_result_wb_buffer_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DEPTH-1:0]  ent_alive;

    logic              ent_regwe   [DEPTH];
    logic              ent_prdtype [DEPTH];
    logic [PRD_W-1:0]  ent_prd     [DEPTH];
    logic [ROB_W-1:0]  ent_rob     [DEPTH];
    logic [KILL_W-1:0] ent_mask    [DEPTH];
    logic [DATA_W-1:0] ent_value   [DEPTH];

    logic buf_empty;
    logic head_alive;
    logic head_hit;
    logic in_killed;
    logic in_live;
    logic stored_valid;
    logic head_drop;
    logic byp_valid;
    logic byp_take;
    logic push;
    logic pop;

    assign buf_empty    = (count == '0);
    assign head_alive   = ent_alive[rd_ptr];
    assign head_hit     = |(ent_mask[rd_ptr] & Kill_VKillMask);
    assign in_killed    = Kill_Enable & (|(wb.In_KillMask & Kill_VKillMask));
    assign in_live      = wb.In_Valid & ~Flush & ~in_killed;
    // A head that is being killed in this cycle is suppressed at once.
    // Its alive bit is cleared at the edge, and it then drains as a dead head.
    assign stored_valid = ~buf_empty & head_alive & ~(Kill_Enable & head_hit) & ~Flush;
    assign head_drop    = ~buf_empty & ~head_alive;

`ifdef IMUL_WB_BYPASS_EN
    assign byp_valid = buf_empty & in_live;
    assign byp_take  = byp_valid & wb.Out_Grant;
`else
    assign byp_valid = 1'b0;
    assign byp_take  = 1'b0;
`endif

    assign wb.In_Ready = (count != FULL_CNT);
    assign push        = in_live & wb.In_Ready & ~byp_take;
    assign pop         = (stored_valid & wb.Out_Grant) | head_drop;
    assign wb.Out_Valid = stored_valid | byp_valid;

    // Output payload: the head entry, the bypassed input, or all zeros when idle.
    always_comb begin
        wb.Out_RegWe    = 1'b0;
        wb.Out_PrdType  = 1'b0;
        wb.Out_Prd      = '0;
        wb.Out_RobIndex = '0;
        wb.Out_Value    = '0;
        if (stored_valid) begin
            wb.Out_RegWe    = ent_regwe[rd_ptr];
            wb.Out_PrdType  = ent_prdtype[rd_ptr];
            wb.Out_Prd      = ent_prd[rd_ptr];
            wb.Out_RobIndex = ent_rob[rd_ptr];
            wb.Out_Value    = ent_value[rd_ptr];
        end else if (byp_valid) begin
            wb.Out_RegWe    = wb.In_RegWe;
            wb.Out_PrdType  = wb.In_PrdType;
            wb.Out_Prd      = wb.In_Prd;
            wb.Out_RobIndex = wb.In_RobIndex;
            wb.Out_Value    = wb.In_Value;
        end
    end

    // Pointer, occupancy and alive-bit bookkeeping; a kill only clears alive bits.
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_alive <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (Kill_Enable && (|(ent_mask[i] & Kill_VKillMask)))
                    ent_alive[i] <= 1'b0;
            end
            if (push) begin
                ent_alive[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Payload storage needs no reset: it is only visible through a live head.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_regwe[wr_ptr]   <= wb.In_RegWe;
            ent_prdtype[wr_ptr] <= wb.In_PrdType;
            ent_prd[wr_ptr]     <= wb.In_Prd;
            ent_rob[wr_ptr]     <= wb.In_RobIndex;
            ent_mask[wr_ptr]    <= wb.In_KillMask;
            ent_value[wr_ptr]   <= wb.In_Value;
        end
    end

`ifndef SYNTHESIS
    // The multiplier must not offer a result while the buffer is full; such a result is lost.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(wb.In_Valid && !wb.In_Ready))
        else $warning("imul_result_wb_buffer: result offered while full was dropped");
`endif

endmodule

// File: tb/tb_imul_result_wb_buffer.sv
// Bench for imul_result_wb_buffer.
// A directed vector table covers the documented scenarios. A randomized phase
// then checks the design against a queue-based reference model.
module tb_imul_result_wb_buffer;
`ifdef IMUL_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       kill_en;
    logic [3:0] kill_vk;

    int checks = 0;
    int errors = 0;

    imul_result_wb_buffer_if bus ();

    imul_result_wb_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .Flush          (flush),
        .Kill_Enable    (kill_en),
        .Kill_VKillMask (kill_vk),
        .wb             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         fl, ke;
        logic [3:0] vk;
        bit         iv;
        logic [6:0] prd;
        logic [5:0] rob;
        logic [3:0] km;
        logic [63:0] val;
        bit         gr;
        bit         ev, er;
        logic [6:0] eprd;
        logic [5:0] erob;
        logic [63:0] evl;
    } vec_t;

    typedef struct {
        logic       regwe, prdtype;
        logic [6:0] prd;
        logic [5:0] rob;
        logic [3:0] km;
        logic [63:0] val;
        bit         alive;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [127:0] out_payload();
        return {49'd0, bus.Out_RegWe, bus.Out_PrdType, bus.Out_Prd, bus.Out_RobIndex, bus.Out_Value};
    endfunction

    task automatic add(input bit fl, input bit ke, input logic [3:0] vk, input bit iv,
                       input logic [6:0] prd, input logic [5:0] rob, input logic [3:0] km,
                       input logic [63:0] val, input bit gr, input bit ev, input bit er,
                       input logic [6:0] eprd, input logic [5:0] erob, input logic [63:0] evl);
        vec_t v;
        v.fl = fl; v.ke = ke; v.vk = vk; v.iv = iv; v.prd = prd; v.rob = rob;
        v.km = km; v.val = val; v.gr = gr; v.ev = ev; v.er = er;
        v.eprd = eprd; v.erob = erob; v.evl = evl;
        vecs.push_back(v);
    endtask

    // Rows whose payload is derived from the ROB index: prd = rob+32, value = 0x100+rob.
    task automatic addp(input bit fl, input bit ke, input logic [3:0] vk, input bit iv,
                        input logic [5:0] rob, input logic [3:0] km, input bit gr,
                        input bit ev, input bit er, input logic [5:0] erob);
        add(fl, ke, vk, iv, 7'(rob) + 7'd32, rob, km, 64'h100 + 64'(rob), gr, ev, er,
            ev ? 7'(erob) + 7'd32 : 7'd0, ev ? erob : 6'd0, ev ? 64'h100 + 64'(erob) : 64'd0);
    endtask

    task automatic idle_inputs();
        flush = 0; kill_en = 0; kill_vk = 0;
        bus.In_Valid = 0; bus.In_RegWe = 0; bus.In_PrdType = 0; bus.In_Prd = 0;
        bus.In_RobIndex = 0; bus.In_KillMask = 0; bus.In_Value = 0; bus.Out_Grant = 0;
    endtask

    initial begin
        logic [63:0] db;
        db = 64'h0000_0000_DEAD_BEEF;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out_valid", 128'(bus.Out_Valid), 128'd0);
        chk("reset_in_ready", 128'(bus.In_Ready), 128'd1);
        chk("reset_payload", out_payload(), 128'd0);
        @(posedge clk); #1;
        rst = 0;

        // Single result held without grant, then granted.
        add(0,0,0,1, 7'd5, 6'd12, 4'd0, db, 0, BYP, 1, BYP ? 7'd5 : 7'd0, BYP ? 6'd12 : 6'd0, BYP ? db : 64'd0);
        for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,0, 0, 1,1, 7'd5, 6'd12, db);
        add(0,0,0,0, 0,0,0,0, 1, 1,1, 7'd5, 6'd12, db);
        addp(0,0,0,0, 0,0,0, 0,1,0);
        // Fill to full, offer a fifth, then drain in order.
        addp(0,0,0,1, 1,0,0, BYP,1, BYP ? 6'd1 : 6'd0);
        addp(0,0,0,1, 2,0,0, 1,1,1);
        addp(0,0,0,1, 3,0,0, 1,1,1);
        addp(0,0,0,1, 4,0,0, 1,1,1);
        addp(0,0,0,1, 5,0,0, 1,0,1);
        addp(0,0,0,0, 0,0,1, 1,0,1);
        addp(0,0,0,0, 0,0,1, 1,1,2);
        addp(0,0,0,0, 0,0,1, 1,1,3);
        addp(0,0,0,0, 0,0,1, 1,1,4);
        addp(0,0,0,0, 0,0,0, 0,1,0);
        // Kill of masks 0001 leaves only ROB 2.
        addp(0,0,0,1, 1,4'b0001,0, BYP,1, BYP ? 6'd1 : 6'd0);
        addp(0,0,0,1, 2,4'b0010,0, 1,1,1);
        addp(0,0,0,1, 3,4'b0001,0, 1,1,1);
        addp(0,1,4'b0001,0, 0,0,0, 0,1,0);
        addp(0,0,0,0, 0,0,0, 0,1,0);
        addp(0,0,0,0, 0,0,1, 1,1,2);
        addp(0,0,0,0, 0,0,0, 0,1,0);
        addp(0,0,0,0, 0,0,0, 0,1,0);
        // Flush with a same-cycle push empties everything.
        addp(0,0,0,1, 7,0,0, BYP,1, BYP ? 6'd7 : 6'd0);
        addp(0,0,0,1, 8,0,0, 1,1,7);
        addp(0,0,0,1, 9,0,0, 1,1,7);
        addp(1,0,0,1, 10,0,0, 0,1,0);
        addp(0,0,0,0, 0,0,0, 0,1,0);
        addp(0,0,0,1, 11,0,0, BYP,1, BYP ? 6'd11 : 6'd0);
        addp(0,0,0,0, 0,0,1, 1,1,11);
        addp(0,0,0,0, 0,0,0, 0,1,0);
        // Push into empty with grant: bypass consumes it at once, otherwise it appears a cycle later.
        addp(0,0,0,1, 9,0,1, BYP,1, BYP ? 6'd9 : 6'd0);
        addp(0,0,0,0, 0,0,0, !BYP,1, BYP ? 6'd0 : 6'd9);
        addp(0,0,0,0, 0,0,1, !BYP,1, BYP ? 6'd0 : 6'd9);
        addp(0,0,0,0, 0,0,0, 0,1,0);
        // An input killed in its own cycle is dropped.
        addp(0,1,4'b0100,1, 3,4'b0100,0, 0,1,0);
        addp(0,0,0,0, 0,0,0, 0,1,0);

        foreach (vecs[i]) begin
            flush = vecs[i].fl; kill_en = vecs[i].ke; kill_vk = vecs[i].vk;
            bus.In_Valid = vecs[i].iv; bus.In_RegWe = vecs[i].iv; bus.In_PrdType = 0;
            bus.In_Prd = vecs[i].prd; bus.In_RobIndex = vecs[i].rob;
            bus.In_KillMask = vecs[i].km; bus.In_Value = vecs[i].val;
            bus.Out_Grant = vecs[i].gr;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 128'(bus.Out_Valid), 128'(vecs[i].ev));
            chk($sformatf("vec%0d_in_ready", i), 128'(bus.In_Ready), 128'(vecs[i].er));
            chk($sformatf("vec%0d_payload", i), out_payload(),
                {49'd0, vecs[i].ev, 1'b0, vecs[i].eprd, vecs[i].erob, vecs[i].evl});
            @(posedge clk); #1;
        end

        // Randomized phase against the queue model; the buffer is empty at this point.
        q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit exp_valid, exp_ready, in_live, do_pop, byp_take;
            logic [127:0] exp_pl;
            int size0;
            idle_inputs();
            rst     = ($urandom_range(0, 299) == 0);
            flush   = ($urandom_range(0, 39) == 0);
            kill_en = ($urandom_range(0, 7) == 0);
            kill_vk = 4'($urandom);
            bus.In_Valid    = (q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            bus.In_RegWe    = 1'($urandom);
            bus.In_PrdType  = 1'($urandom);
            bus.In_Prd      = 7'($urandom);
            bus.In_RobIndex = 6'($urandom);
            bus.In_KillMask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            bus.In_Value    = {32'($urandom), 32'($urandom)};
            bus.Out_Grant   = ($urandom_range(0, 2) != 0);
            @(negedge clk);

            size0     = q.size();
            exp_ready = (size0 != DEPTH);
            in_live   = bus.In_Valid && !flush && !(kill_en && |(bus.In_KillMask & kill_vk));
            exp_valid = 0;
            exp_pl    = '0;
            if (!flush && size0 > 0) begin
                exp_valid = q[0].alive && !(kill_en && |(q[0].km & kill_vk));
                if (exp_valid)
                    exp_pl = {49'd0, q[0].regwe, q[0].prdtype, q[0].prd, q[0].rob, q[0].val};
            end else if (BYP && size0 == 0 && in_live) begin
                exp_valid = 1;
                exp_pl = {49'd0, bus.In_RegWe, bus.In_PrdType, bus.In_Prd, bus.In_RobIndex, bus.In_Value};
            end
            chk("rand_out_valid", 128'(bus.Out_Valid), 128'(exp_valid));
            chk("rand_in_ready", 128'(bus.In_Ready), 128'(exp_ready));
            chk("rand_payload", out_payload(), exp_pl);

            if (rst || flush) begin
                q.delete();
            end else begin
                do_pop   = (size0 > 0) && ((exp_valid && bus.Out_Grant) || !q[0].alive);
                byp_take = BYP && size0 == 0 && in_live && bus.Out_Grant;
                if (do_pop) void'(q.pop_front());
                if (kill_en)
                    foreach (q[k])
                        if (|(q[k].km & kill_vk)) q[k].alive = 0;
                if (in_live && size0 != DEPTH && !byp_take) begin
                    ent_t e;
                    e.regwe = bus.In_RegWe; e.prdtype = bus.In_PrdType; e.prd = bus.In_Prd;
                    e.rob = bus.In_RobIndex; e.km = bus.In_KillMask; e.val = bus.In_Value;
                    e.alive = 1;
                    q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
